// File: rtl/comp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
// State encoding, result-flag reset values and a constant-evaluable clog2.
package comp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic GT_RST = 1'b0;
  localparam logic LT_RST = 1'b0;
  localparam logic EQ_RST = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/comp_serial_if.sv
// Request/result bundle between a requester and comp_serial.
// The requester drives operands and start; the comparator returns status and flags.
interface comp_serial_if
  import comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) ();

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = clog2(NCH + 1);

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             agtb;
  logic             altb;
  logic             aeqb;
  logic [CW-1:0]    cycles;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, agtb, altb, aeqb, cycles
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, agtb, altb, aeqb, cycles
  );

endinterface

// File: rtl/comp_chunk.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice.
// Exactly one of gt/lt/eq is high for any pair of inputs.
module comp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/comp_serial.sv
// Multi-cycle WIDTH-bit magnitude comparator: scans CHUNK bits per clock from the
// most significant chunk down and stops at the first chunk that differs.
module comp_serial
  import comp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic          clk,
  input  logic          rst,
  comp_serial_if.slave  bus
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int CW    = clog2(NCH + 1);
  localparam int IW    = (NCH > 1) ? clog2(NCH) : 1;
  localparam int NSLOT = 1 << IW;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_width
      $error("comp_serial: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [IW-1:0]    idx_reg, idx_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [CW-1:0]    cycles_reg, cycles_next;
  logic             done_reg, done_next;
  logic             gt_reg, gt_next;
  logic             lt_reg, lt_next;
  logic             eq_reg, eq_next;

  // Chunk mux: pad to a power of two so idx never selects outside the array.
  logic [CHUNK-1:0] a_slot [NSLOT];
  logic [CHUNK-1:0] b_slot [NSLOT];
  logic [CHUNK-1:0] a_sel, b_sel;
  logic             chunk_gt, chunk_lt, chunk_eq;

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NCH) begin : g_used
        assign a_slot[gi] = a_reg[gi*CHUNK +: CHUNK];
        assign b_slot[gi] = b_reg[gi*CHUNK +: CHUNK];
      end else begin : g_pad
        assign a_slot[gi] = '0;
        assign b_slot[gi] = '0;
      end
    end
  endgenerate

  assign a_sel = a_slot[idx_reg];
  assign b_sel = b_slot[idx_reg];

  comp_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (a_sel),
    .b  (b_sel),
    .gt (chunk_gt),
    .lt (chunk_lt),
    .eq (chunk_eq)
  );

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    idx_next    = idx_reg;
    cnt_next    = cnt_reg;
    cycles_next = cycles_reg;
    done_next   = 1'b0;
    gt_next     = gt_reg;
    lt_next     = lt_reg;
    eq_next     = eq_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          a_next     = bus.a ^ (bus.signed_mode ? MSB_MASK : '0);
          b_next     = bus.b ^ (bus.signed_mode ? MSB_MASK : '0);
          idx_next   = IW'(NCH - 1);
          cnt_next   = CW'(1);
          state_next = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (!chunk_eq) begin
          gt_next     = chunk_gt;
          lt_next     = chunk_lt;
          eq_next     = 1'b0;
          cycles_next = cnt_reg;
          done_next   = 1'b1;
          state_next  = ST_IDLE;
        end else if (idx_reg == '0) begin
          gt_next     = 1'b0;
          lt_next     = 1'b0;
          eq_next     = 1'b1;
          cycles_next = cnt_reg;
          done_next   = 1'b1;
          state_next  = ST_IDLE;
        end else begin
          idx_next = idx_reg - IW'(1);
          cnt_next = cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      done_reg   <= 1'b0;
      gt_reg     <= GT_RST;
      lt_reg     <= LT_RST;
      eq_reg     <= EQ_RST;
      cycles_reg <= '0;
    end else begin
      state_reg  <= state_next;
      done_reg   <= done_next;
      gt_reg     <= gt_next;
      lt_reg     <= lt_next;
      eq_reg     <= eq_next;
      cycles_reg <= cycles_next;
    end
  end

  // Datapath registers are only meaningful during SCAN, so they carry no reset.
  always_ff @(posedge clk) begin
    a_reg   <= a_next;
    b_reg   <= b_next;
    idx_reg <= idx_next;
    cnt_reg <= cnt_next;
  end

  assign bus.busy   = (state_reg == ST_SCAN);
  assign bus.done   = done_reg;
  assign bus.agtb   = gt_reg;
  assign bus.altb   = lt_reg;
  assign bus.aeqb   = eq_reg;
  assign bus.cycles = cycles_reg;

endmodule

// File: tb/tb_comp_serial.sv
// Bench for comp_serial: three instances (CHUNK = 4, 16, 1) at WIDTH = 16 share
// operands and are checked against a whole-word reference compare.
module tb_comp_serial;

  localparam int WIN = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = '0;
  logic        sm = 1'b0;
  logic [15:0] opa = '0;
  logic [15:0] opb = '0;

  always #5 clk = ~clk;

  comp_serial_if #(.WIDTH(16), .CHUNK(4))  if_c4  ();
  comp_serial_if #(.WIDTH(16), .CHUNK(16)) if_c16 ();
  comp_serial_if #(.WIDTH(16), .CHUNK(1))  if_c1  ();

  assign if_c4.start  = start_v[0];
  assign if_c16.start = start_v[1];
  assign if_c1.start  = start_v[2];
  assign if_c4.signed_mode  = sm;
  assign if_c16.signed_mode = sm;
  assign if_c1.signed_mode  = sm;
  assign if_c4.a  = opa;
  assign if_c4.b  = opb;
  assign if_c16.a = opa;
  assign if_c16.b = opb;
  assign if_c1.a  = opa;
  assign if_c1.b  = opb;

  comp_serial #(.WIDTH(16), .CHUNK(4))  dut_c4  (.clk(clk), .rst(rst), .bus(if_c4));
  comp_serial #(.WIDTH(16), .CHUNK(16)) dut_c16 (.clk(clk), .rst(rst), .bus(if_c16));
  comp_serial #(.WIDTH(16), .CHUNK(1))  dut_c1  (.clk(clk), .rst(rst), .bus(if_c1));

  logic       busy_v  [3];
  logic       done_v  [3];
  logic [2:0] flags_v [3];
  logic [4:0] cyc_v   [3];

  assign busy_v[0]  = if_c4.busy;
  assign busy_v[1]  = if_c16.busy;
  assign busy_v[2]  = if_c1.busy;
  assign done_v[0]  = if_c4.done;
  assign done_v[1]  = if_c16.done;
  assign done_v[2]  = if_c1.done;
  assign flags_v[0] = {if_c4.agtb,  if_c4.altb,  if_c4.aeqb};
  assign flags_v[1] = {if_c16.agtb, if_c16.altb, if_c16.aeqb};
  assign flags_v[2] = {if_c1.agtb,  if_c1.altb,  if_c1.aeqb};
  assign cyc_v[0]   = {2'b00, if_c4.cycles};
  assign cyc_v[1]   = {4'b0000, if_c16.cycles};
  assign cyc_v[2]   = if_c1.cycles;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: the result each instance should currently be holding.
  logic [2:0] mflags [3];
  int         mcyc   [3];

  function automatic int chunk_of(input int i);
    if (i == 0) return 4;
    if (i == 1) return 16;
    return 1;
  endfunction

  // Chunks examined = chunks from the top down to the one holding the highest differing bit.
  function automatic int chunks_examined(input logic [15:0] x, input logic [15:0] y, input int chunk);
    logic [15:0] d;
    int top;
    d = x ^ y;
    top = -1;
    for (int k = 0; k < 16; k++) begin
      if (d[k]) top = k;
    end
    if (top < 0) return 16 / chunk;
    return 16 / chunk - top / chunk;
  endfunction

  function automatic logic [2:0] ref_flags(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic gt, lt;
    if (s) begin
      gt = $signed(x) > $signed(y);
      lt = $signed(x) < $signed(y);
    end else begin
      gt = x > y;
      lt = x < y;
    end
    return {gt, lt, !(gt || lt)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start the instances in mask at cycle T; optionally raise start again at offset inj_off.
  task automatic run_txn(input logic [15:0] ta, input logic [15:0] tbv, input logic tsm,
                         input logic [2:0] mask, input int inj_off,
                         input logic [15:0] ia, input logic [15:0] ib, input logic [2:0] imask);
    logic [63:0] busy_exp [3];
    logic [63:0] done_exp [3];
    logic [63:0] busy_obs [3];
    logic [63:0] done_obs [3];
    logic [2:0]  last_flags [3];
    logic        unstable [3];
    for (int i = 0; i < 3; i++) begin
      int n1, n2;
      n1 = 0;
      busy_exp[i] = '0;
      done_exp[i] = '0;
      busy_obs[i] = '0;
      done_obs[i] = '0;
      unstable[i] = 1'b0;
      last_flags[i] = mflags[i];
      if (mask[i]) begin
        n1 = chunks_examined(ta, tbv, chunk_of(i));
        for (int k = 1; k <= n1; k++) busy_exp[i][k] = 1'b1;
        done_exp[i][1 + n1] = 1'b1;
        mflags[i] = ref_flags(ta, tbv, tsm);
        mcyc[i] = n1;
      end
      // A second start is honoured only if the instance is idle in that cycle.
      if (inj_off > 0 && imask[i] && (!mask[i] || inj_off >= 1 + n1)) begin
        n2 = chunks_examined(ia, ib, chunk_of(i));
        for (int k = 1; k <= n2; k++) busy_exp[i][inj_off + k] = 1'b1;
        done_exp[i][inj_off + 1 + n2] = 1'b1;
        mflags[i] = ref_flags(ia, ib, tsm);
        mcyc[i] = n2;
      end
    end

    opa = ta;
    opb = tbv;
    sm = tsm;
    start_v = mask;
    @(posedge clk);
    @(negedge clk);
    start_v = '0;
    for (int off = 1; off <= WIN; off++) begin
      for (int i = 0; i < 3; i++) begin
        busy_obs[i][off] = busy_v[i];
        done_obs[i][off] = done_v[i];
        if (!$onehot(flags_v[i]) || (flags_v[i] !== last_flags[i] && !done_v[i]))
          unstable[i] = 1'b1;
        last_flags[i] = flags_v[i];
      end
      if (inj_off > 0 && off == inj_off) begin
        opa = ia;
        opb = ib;
        start_v = imask;
      end else begin
        start_v = '0;
      end
      @(negedge clk);
    end

    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy_pattern c%0d a=%h b=%h s=%0d", chunk_of(i), ta, tbv, tsm), busy_obs[i], busy_exp[i]);
      check($sformatf("done_pattern c%0d a=%h b=%h s=%0d", chunk_of(i), ta, tbv, tsm), done_obs[i], done_exp[i]);
      check($sformatf("flags c%0d a=%h b=%h s=%0d", chunk_of(i), ta, tbv, tsm), 64'(flags_v[i]), 64'(mflags[i]));
      check($sformatf("cycles c%0d a=%h b=%h s=%0d", chunk_of(i), ta, tbv, tsm), 64'(cyc_v[i]), 64'(mcyc[i]));
      check($sformatf("stable_onehot c%0d", chunk_of(i)), 64'(unstable[i]), 64'd0);
    end
  endtask

  initial begin
    logic [15:0] x, y;
    logic        rs;
    logic        seen;

    for (int i = 0; i < 3; i++) begin
      mflags[i] = 3'b001;
      mcyc[i] = 0;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy_done c%0d", chunk_of(i)), 64'({busy_v[i], done_v[i]}), 64'd0);
      check($sformatf("rst_flags c%0d", chunk_of(i)), 64'(flags_v[i]), 64'(3'b001));
      check($sformatf("rst_cycles c%0d", chunk_of(i)), 64'(cyc_v[i]), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_txn(16'h1234, 16'h1234, 1'b0, 3'b111, 0, 16'h0, 16'h0, 3'b000);
    run_txn(16'h8000, 16'h7FFF, 1'b0, 3'b111, 0, 16'h0, 16'h0, 3'b000);
    run_txn(16'h8000, 16'h7FFF, 1'b1, 3'b111, 0, 16'h0, 16'h0, 3'b000);
    run_txn(16'h00A5, 16'h00A6, 1'b0, 3'b111, 0, 16'h0, 16'h0, 3'b000);
    run_txn(16'hFFFF, 16'hFFFE, 1'b1, 3'b111, 0, 16'h0, 16'h0, 3'b000);
    // start during busy is ignored
    run_txn(16'h0001, 16'h0002, 1'b0, 3'b001, 2, 16'h0009, 16'h0000, 3'b001);
    // start held in the done cycle is accepted
    run_txn(16'h8000, 16'h7FFF, 1'b0, 3'b001, 2, 16'h1234, 16'h1234, 3'b001);

    // Reset in T+2 of a four-chunk scan on the CHUNK=4 instance.
    opa = 16'h0001;
    opb = 16'h0000;
    sm = 1'b0;
    start_v = 3'b001;
    @(posedge clk);
    @(negedge clk);
    start_v = '0;
    check("rst_scan_busy_t1", 64'(busy_v[0]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mflags[i] = 3'b001;
      mcyc[i] = 0;
    end
    check("rst_scan_busy_t3", 64'(busy_v[0]), 64'd0);
    check("rst_scan_flags", 64'(flags_v[0]), 64'(3'b001));
    check("rst_scan_cycles", 64'(cyc_v[0]), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done_v[0] || busy_v[0]) seen = 1'b1;
      @(negedge clk);
    end
    check("rst_scan_no_done", 64'(seen), 64'd0);

    for (int t = 0; t < 40; t++) begin
      x = 16'($urandom);
      case ($urandom_range(0, 3))
        0: y = 16'($urandom);
        1: y = x;
        2: y = x ^ (16'd1 << $urandom_range(0, 15));
        default: y = x ^ 16'($urandom_range(1, 15));
      endcase
      rs = 1'($urandom_range(0, 1));
      run_txn(x, y, rs, 3'b111, 0, 16'h0, 16'h0, 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/comp_serial.md
# comp_serial

Parametrised, multi-cycle magnitude comparator for WIDTH-bit operands. Scans CHUNK bits per clock, MSB chunk first, and stops at the first differing chunk. Adds signed/unsigned mode and a start/busy/done handshake. Registered agtb/altb/aeqb flags keep the combinational comparator's semantics, so wide compares need no long ripple path and meet timing.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; CHUNK = WIDTH gives a single-cycle scan.
- NCH (localparam), WIDTH/CHUNK, number of chunks; CW = clog2(NCH+1).
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement compare; 0 = unsigned; latched with start.
- a  in  WIDTH  operand A; latched with start.
- b  in  WIDTH  operand B; latched with start.
- busy  out  1  high while SCAN.
- done  out  1  one-cycle pulse when a result is written.
- agtb  out  1  A > B; held until the next done.
- altb  out  1  A < B; held until the next done.
- aeqb  out  1  A == B; held until the next done.
- cycles  out  CW  number of chunks examined for the last result (1..NCH).

## Operation
- States: IDLE, SCAN.
- IDLE, start=1:
  - Latch a_r = a and b_r = b. If signed_mode, invert bit WIDTH-1 of both, which reduces a signed compare to an unsigned one.
  - Set idx = NCH-1 and cnt = 1, then go to SCAN.
- IDLE, start=0: hold state.
- SCAN, each cycle: compare chunk idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK) of a_r and b_r.
  - Chunks differ: agtb = chunk gt, altb = chunk lt, aeqb = 0, cycles = cnt, done = 1, go to IDLE.
  - Chunks equal and idx = 0: agtb = 0, altb = 0, aeqb = 1, cycles = cnt, done = 1, go to IDLE.
  - Otherwise: idx -= 1, cnt += 1, stay in SCAN.
- start during SCAN is ignored; the latched operands are not disturbed.
- Exactly one of agtb/altb/aeqb is high at all times.
- WIDTH % CHUNK != 0 is an elaboration-time error.

## Timing
- Reset values: state IDLE, busy 0, done 0, agtb 0, altb 0, aeqb 1, cycles 0. Internal idx, cnt, a_r and b_r are don't-care.
- If start is sampled in cycle T and n chunks are examined, done and the new result are visible in cycle T+1+n.
  - Best case: T+2.
  - Worst case (equal operands, or a difference in chunk 0): T+1+NCH.
- busy is high in cycles T+1 .. T+n, and low in the done cycle.
- Result flags and cycles change only in the done cycle; between results they are stable.
- Back-to-back requests: start sampled in the done cycle (state already IDLE) is accepted, giving busy again in the next cycle. Throughput is one compare per n+1 cycles.
- rst has priority over everything:
  - rst in any cycle, including mid-SCAN, forces the reset values at the next edge.
  - No done pulse is issued for the aborted compare.
  - A start coincident with rst is dropped.
- NCH = 1: SCAN lasts exactly one cycle; cycles = 1 always.

## Structure
- Package comp_pkg:
  - state encoding (IDLE = 0, SCAN = 1);
  - a clog2 function;
  - result-flag reset constants (GT_RST = 0, LT_RST = 0, EQ_RST = 1).
- Sub-module comp_chunk: combinational CHUNK-bit unsigned magnitude compare with outputs gt, lt, eq. One instance, fed by a chunk mux on idx.
- Top level holds the FSM, operand registers, idx/cnt counters and output registers.

## Test plan
WIDTH = 16, CHUNK = 4 unless noted; start pulsed in cycle T.
- Equal: a = 16'h1234, b = 16'h1234, unsigned -> aeqb = 1, agtb = altb = 0, cycles = 4, done in T+5, busy high T+1..T+4.
- Early exit and sign: a = 16'h8000, b = 16'h7FFF.
  - Unsigned -> agtb = 1, cycles = 1, done in T+2.
  - Repeat with signed_mode = 1 -> altb = 1, cycles = 1.
- Late difference and negative values:
  - a = 16'h00A5, b = 16'h00A6, unsigned -> altb = 1, cycles = 4.
  - Signed a = 16'hFFFF, b = 16'hFFFE -> agtb = 1, cycles = 4.
- Handshake:
  - Pulse start with a = 1, b = 2, then pulse start during busy with a = 9, b = 0 -> a single result altb = 1; the second request is ignored.
  - Start held in the done cycle -> busy = 1 on the next cycle, and a new result follows.
- Reset mid-scan: a = 16'h0001, b = 16'h0000, rst asserted in T+2 -> from T+3 busy = 0, done never pulses, aeqb = 1, cycles = 0.
- Parameter sweep: CHUNK = 16 and CHUNK = 1 with WIDTH = 16; random operands in both modes checked against a reference compare.
  - Done latency equals 1 + (index of the first differing chunk, counted from the top, plus 1).
